// File: rtl/mtr_spd_slew.sv
// mtr_spd_slew: conditions raw signed speed commands for the H-bridge driver.
// Clamps commands, slew-limits both outputs on a shared tick, enforces a
// zero-speed dwell before any direction reversal, and forces zero on fault.
module mtr_spd_slew #(
   parameter int unsigned TICK_DIV   = 1024,
   parameter int unsigned STEP       = 8,
   parameter int unsigned MAX_SPD    = 2000,
   parameter int unsigned ZERO_DWELL = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [11:0] lft_cmd,
   input  logic signed [11:0] rght_cmd,
   input  logic               cmd_vld,
   input  logic               mtr_en,
   input  logic               OVR_I_shtdwn,
   output logic signed [11:0] lft_spd,
   output logic signed [11:0] rght_spd,
   output logic               at_target,
   output logic               fault
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW = $clog2(ZERO_DWELL + 1);
   localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DWELL_LAST   = DW'(ZERO_DWELL - 1);
   localparam logic signed [12:0] STEP_S  = 13'(STEP);
   localparam logic signed [12:0] MAX_S   = 13'(MAX_SPD);
   localparam logic signed [12:0] MIN_S   = -MAX_S;

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_FAULT} state_t;

   state_t                r_state, w_state_nxt;
   logic [PW-1:0]         r_pre;
   logic                  w_tick;
   logic                  w_run, w_force0;
   logic signed [11:0]    r_tgt [2];
   logic signed [11:0]    w_out [2];
   logic                  r_at, r_fault;

   function automatic logic signed [11:0] f_clamp(input logic signed [11:0] i_c);
      logic signed [12:0] w_c;
      w_c = {i_c[11], i_c};
      if (w_c > MAX_S)      return MAX_S[11:0];
      else if (w_c < MIN_S) return MIN_S[11:0];
      else                  return i_c;
   endfunction

   assign w_tick = (r_pre == PRE_LAST);

   // Free-running tick prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pre <= '0;
      else if (w_tick) r_pre <= '0;
      else             r_pre <= r_pre + PW'(1);
   end

   // Command latch with clamp, active in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tgt[0] <= '0;
         r_tgt[1] <= '0;
      end else if (cmd_vld) begin
         r_tgt[0] <= f_clamp(lft_cmd);
         r_tgt[1] <= f_clamp(rght_cmd);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_STOP;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: shutdown dominates, FAULT is left only by reset
   always_comb begin
      w_state_nxt = r_state;
      if (OVR_I_shtdwn) begin
         w_state_nxt = ST_FAULT;
      end else begin
         case (r_state)
            ST_STOP:  if (mtr_en)  w_state_nxt = ST_RUN;
            ST_RUN:   if (!mtr_en) w_state_nxt = ST_STOP;
            default:  w_state_nxt = ST_FAULT;
         endcase
      end
   end

   // FSM outputs: target gating and immediate zero forcing
   always_comb begin
      w_run    = (r_state == ST_RUN);
      w_force0 = (w_state_nxt == ST_FAULT);
   end

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic signed [11:0] r_out;
      logic               r_armed, r_dir;
      logic [DW-1:0]      r_dwell;
      logic signed [11:0] w_eff;
      logic signed [12:0] w_diff, w_cand;
      logic               w_rev;
      logic signed [11:0] w_out_nxt;
      logic               w_armed_nxt, w_dir_nxt;
      logic [DW-1:0]      w_dwell_nxt;

      // Per-channel slew step with reversal dwell; the step is clipped so it
      // never carries the output across zero in one tick
      always_comb begin
         w_eff       = w_run ? r_tgt[g] : '0;
         w_diff      = {w_eff[11], w_eff} - {r_out[11], r_out};
         w_rev       = (r_out == '0) && r_armed && (w_eff != '0) && (w_eff[11] != r_dir);
         w_cand      = '0;
         w_out_nxt   = r_out;
         w_armed_nxt = r_armed;
         w_dir_nxt   = r_dir;
         w_dwell_nxt = r_dwell;
         if (w_rev) begin
            if (r_dwell == DWELL_LAST) begin
               w_armed_nxt = 1'b0;
               w_dwell_nxt = '0;
            end else begin
               w_dwell_nxt = r_dwell + DW'(1);
            end
         end else begin
            w_dwell_nxt = '0;
            if (w_diff > STEP_S)       w_cand = {r_out[11], r_out} + STEP_S;
            else if (w_diff < -STEP_S) w_cand = {r_out[11], r_out} - STEP_S;
            else                       w_cand = {w_eff[11], w_eff};
            if ((r_out != '0) && (w_cand != '0) && (w_cand[12] != r_out[11]))
               w_cand = '0;
            w_out_nxt = w_cand[11:0];
            if (w_cand != '0) begin
               w_armed_nxt = 1'b1;
               w_dir_nxt   = w_cand[12];
            end
         end
      end

      // Per-channel output and dwell state; fault forces zero without a ramp
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_out   <= '0;
            r_armed <= 1'b0;
            r_dir   <= 1'b0;
            r_dwell <= '0;
         end else if (w_force0) begin
            r_out   <= '0;
         end else if (w_tick) begin
            r_out   <= w_out_nxt;
            r_armed <= w_armed_nxt;
            r_dir   <= w_dir_nxt;
            r_dwell <= w_dwell_nxt;
         end
      end

      assign w_out[g] = r_out;
   end

   // Registered status; at_target only while RUN persists across the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_at    <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_at    <= w_run && (w_state_nxt == ST_RUN) &&
                    (w_out[0] == r_tgt[0]) && (w_out[1] == r_tgt[1]);
         r_fault <= (w_state_nxt == ST_FAULT);
      end
   end

   assign lft_spd   = w_out[0];
   assign rght_spd  = w_out[1];
   assign at_target = r_at;
   assign fault     = r_fault;

endmodule

// File: tb/tb_mtr_spd_slew.sv
// Self-checking bench for mtr_spd_slew: behavioural model plus directed pins.
module tb_mtr_spd_slew;

   localparam int TD = 4;
   localparam int ST = 16;
   localparam int MX = 2000;
   localparam int ZD = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic signed [11:0] lft_cmd, rght_cmd;
   logic              cmd_vld, mtr_en, OVR_I_shtdwn;
   logic signed [11:0] lft_spd, rght_spd;
   logic              at_target, fault;

   mtr_spd_slew #(.TICK_DIV(TD), .STEP(ST), .MAX_SPD(MX), .ZERO_DWELL(ZD)) dut (
      .clk(clk), .rst_n(rst_n), .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
      .cmd_vld(cmd_vld), .mtr_en(mtr_en), .OVR_I_shtdwn(OVR_I_shtdwn),
      .lft_spd(lft_spd), .rght_spd(rght_spd), .at_target(at_target), .fault(fault)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // modes: 0 stopped, 1 running, 2 faulted
   int m_mode, m_pre, m_at, m_fault;
   int m_tgt [2];
   int m_out [2];
   int m_armed [2];
   int m_neg [2];
   int m_hold [2];

   function automatic int clampv(input int v);
      if (v > MX)  return MX;
      if (v < -MX) return -MX;
      return v;
   endfunction

   task automatic advance(input int c, input int goal);
      int nv;
      if (m_out[c] == 0 && m_armed[c] != 0 && goal != 0 && ((goal < 0) != (m_neg[c] != 0))) begin
         m_hold[c]++;
         if (m_hold[c] == ZD) begin
            m_armed[c] = 0;
            m_hold[c]  = 0;
         end
      end else begin
         m_hold[c] = 0;
         if (goal - m_out[c] > ST)       nv = m_out[c] + ST;
         else if (goal - m_out[c] < -ST) nv = m_out[c] - ST;
         else                            nv = goal;
         if (m_out[c] * nv < 0) nv = 0;
         m_out[c] = nv;
         if (nv != 0) begin
            m_armed[c] = 1;
            m_neg[c]   = (nv < 0) ? 1 : 0;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_pre = 0; m_at = 0; m_fault = 0;
         for (int c = 0; c < 2; c++) begin
            m_tgt[c] = 0; m_out[c] = 0; m_armed[c] = 0; m_neg[c] = 0; m_hold[c] = 0;
         end
      end else begin
         int tick, nmode;
         int goal [2];
         tick  = (m_pre == TD - 1);
         m_pre = tick ? 0 : m_pre + 1;
         if (OVR_I_shtdwn || m_mode == 2) nmode = 2;
         else                             nmode = mtr_en ? 1 : 0;
         for (int c = 0; c < 2; c++) goal[c] = (m_mode == 1) ? m_tgt[c] : 0;
         m_at = (nmode == 1 && m_mode == 1 && m_out[0] == m_tgt[0] && m_out[1] == m_tgt[1]);
         if (nmode == 2) begin
            m_out[0] = 0;
            m_out[1] = 0;
            m_fault  = 1;
         end else if (tick) begin
            advance(0, goal[0]);
            advance(1, goal[1]);
         end
         if (cmd_vld) begin
            m_tgt[0] = clampv(int'(lft_cmd));
            m_tgt[1] = clampv(int'(rght_cmd));
         end
         m_mode = nmode;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("lft_spd",   int'(lft_spd),  m_out[0]);
      chk("rght_spd",  int'(rght_spd), m_out[1]);
      chk("at_target", int'(at_target), m_at);
      chk("fault",     int'(fault),    m_fault);
   end

   // ---------------- left-output change log ----------------
   int cyc_cnt = 0;
   int log_on = 0;
   int prev_l = 0;
   int q_val[$];
   int q_cyc[$];

   always @(posedge clk) cyc_cnt++;

   always @(negedge clk) begin
      if (log_on != 0 && int'(lft_spd) != prev_l) begin
         q_val.push_back(int'(lft_spd));
         q_cyc.push_back(cyc_cnt);
      end
      prev_l = int'(lft_spd);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int l, input int r);
      lft_cmd  = 12'(l);
      rght_cmd = 12'(r);
      cmd_vld  = 1'b1;
      cyc(1);
      cmd_vld  = 1'b0;
   endtask

   function automatic int rnd_cmd();
      int ext [6] = '{2047, -2048, 2000, -2000, 2001, -2001};
      case ($urandom_range(0, 3))
         0:       return int'($signed(12'($urandom_range(0, 4095))));
         1:       return int'($urandom_range(0, 128)) - 64;
         2:       return ext[$urandom_range(0, 5)];
         default: return (int'($urandom_range(0, 2)) - 1) * ST;
      endcase
   endfunction

   initial begin
      int exp3 [6] = '{24, 8, 0, -16, -32, -40};
      rst_n = 1'b0; lft_cmd = '0; rght_cmd = '0; cmd_vld = 1'b0;
      mtr_en = 1'b0; OVR_I_shtdwn = 1'b0;
      cyc(3);
      chk("rst_lft", int'(lft_spd), 0);
      chk("rst_rght", int'(rght_spd), 0);
      chk("rst_fault", int'(fault), 0);
      rst_n = 1'b1;
      cyc(2);

      // basic ramp to +/-100
      mtr_en = 1'b1;
      send(100, -100);
      cyc(40);
      chk("t1_lft", int'(lft_spd), 100);
      chk("t1_rght", int'(rght_spd), -100);
      chk("t1_at", int'(at_target), 1);

      // reversal through zero with dwell
      send(40, -100);
      cyc(40);
      chk("t3_start", int'(lft_spd), 40);
      q_val.delete(); q_cyc.delete();
      log_on = 1;
      send(-40, -100);
      cyc(80);
      log_on = 0;
      chk("t3_nchg", q_val.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("t3_seq", (i < q_val.size()) ? q_val[i] : 99999, exp3[i]);
      chk("t3_hold", (q_cyc.size() >= 4) ? q_cyc[3] - q_cyc[2] : -1, 5 * TD);

      // clamp of extreme commands
      send(2047, -2048);
      cyc(700);
      chk("t2_lft", int'(lft_spd), 2000);
      chk("t2_rght", int'(rght_spd), -2000);

      // disable ramps down, re-enable ramps back
      send(500, -500);
      cyc(450);
      chk("t4_run_lft", int'(lft_spd), 500);
      mtr_en = 1'b0;
      cyc(200);
      chk("t4_stop_lft", int'(lft_spd), 0);
      chk("t4_stop_rght", int'(rght_spd), 0);
      chk("t4_stop_at", int'(at_target), 0);
      mtr_en = 1'b1;
      cyc(200);
      chk("t4_back_lft", int'(lft_spd), 500);
      chk("t4_back_rght", int'(rght_spd), -500);

      // command strobe coincident with a tick edge
      for (int i = 0; i < 2 * TD && m_pre != TD - 1; i++) cyc(1);
      chk("t6_align", m_pre, TD - 1);
      send(300, -300);
      chk("t6_old", int'(lft_spd), 500);
      cyc(TD);
      chk("t6_new", int'(lft_spd), 484);

      // randomized operation without shutdown
      for (int i = 0; i < 3000; i++) begin
         cmd_vld  = ($urandom_range(0, 15) == 0);
         lft_cmd  = 12'(rnd_cmd());
         rght_cmd = 12'(rnd_cmd());
         if ($urandom_range(0, 199) == 0) mtr_en = ~mtr_en;
         cyc(1);
      end
      cmd_vld = 1'b0;

      // shutdown mid-ramp, sticky until reset
      mtr_en = 1'b1;
      send(1000, -1000);
      cyc(12);
      OVR_I_shtdwn = 1'b1;
      cyc(1);
      OVR_I_shtdwn = 1'b0;
      chk("t5_lft", int'(lft_spd), 0);
      chk("t5_rght", int'(rght_spd), 0);
      chk("t5_fault", int'(fault), 1);
      mtr_en = 1'b0; cyc(5); mtr_en = 1'b1;
      send(700, 700);
      cyc(100);
      chk("t5_stick_lft", int'(lft_spd), 0);
      chk("t5_stick_fault", int'(fault), 1);

      // reset clears the fault; then random with rare shutdowns
      rst_n = 1'b0;
      cyc(2);
      chk("rst2_fault", int'(fault), 0);
      chk("rst2_lft", int'(lft_spd), 0);
      rst_n = 1'b1;
      mtr_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         cmd_vld  = ($urandom_range(0, 15) == 0);
         lft_cmd  = 12'(rnd_cmd());
         rght_cmd = 12'(rnd_cmd());
         OVR_I_shtdwn = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      OVR_I_shtdwn = 1'b0;
      cmd_vld = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
